// File: rtl/bcd_updown_timer.sv
// ============================================================================
// Module   : bcd_updown_timer
// Brief    : Multi-digit BCD up/down timer with load, lap freeze and a
//            multiplexed active-low seven-segment display driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_updown_timer #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 4194304,
    parameter int SCAN_DIV = 131072
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  Start_Stop,
    input  logic                  Dir,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Load_Data,
    input  logic                  Lap,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            Seg,
    output logic                  Wrap,
    output logic [4*DIGITS-1:0]   Count
);

    localparam int c_PW = $clog2(TICK_DIV);
    localparam int c_SW = $clog2(SCAN_DIV);
    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [0:0] c_ST_LIVE   = 1'b0;
    localparam logic [0:0] c_ST_FROZEN = 1'b1;

    logic [c_PW-1:0]     r_presc;
    logic [4*DIGITS-1:0] r_count;
    logic                r_wrap;
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [4*DIGITS-1:0] r_disp;
    logic [c_SW-1:0]     r_scan;
    logic [c_IW-1:0]     r_idx;
    logic [7:0]          r_seg;

    logic                w_tick;
    logic [DIGITS:0]     w_carry;
    logic [DIGITS-1:0]   w_at_end;
    logic [4*DIGITS-1:0] w_count_nxt;
    logic [4*DIGITS-1:0] w_load_val;
    logic [3:0]          w_disp_dig [DIGITS];

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'b1000000;
            4'd1:    f_seg7 = 7'b1111001;
            4'd2:    f_seg7 = 7'b0100100;
            4'd3:    f_seg7 = 7'b0110000;
            4'd4:    f_seg7 = 7'b0011001;
            4'd5:    f_seg7 = 7'b0010010;
            4'd6:    f_seg7 = 7'b0000010;
            4'd7:    f_seg7 = 7'b1111000;
            4'd8:    f_seg7 = 7'b0000000;
            4'd9:    f_seg7 = 7'b0010000;
            default: f_seg7 = 7'b1111111;
        endcase
    endfunction

    assign w_tick     = Start_Stop && (r_presc == c_PW'(TICK_DIV - 1));
    assign w_carry[0] = 1'b1;

    // A digit steps only when every lower digit is at its roll-over value.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] w_cur;
        logic [3:0] w_ld;
        assign w_cur         = r_count[4*i +: 4];
        assign w_ld          = Load_Data[4*i +: 4];
        assign w_at_end[i]   = Dir ? (w_cur == 4'd9) : (w_cur == 4'd0);
        assign w_carry[i+1]  = w_carry[i] & w_at_end[i];
        assign w_count_nxt[4*i +: 4] = !w_carry[i] ? w_cur :
                                       w_at_end[i] ? (Dir ? 4'd0 : 4'd9) :
                                       Dir         ? (w_cur + 4'd1) : (w_cur - 4'd1);
        assign w_load_val[4*i +: 4]  = (w_ld > 4'd9) ? 4'd0 : w_ld;
        assign w_disp_dig[i]         = r_disp[4*i +: 4];
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_presc <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            if (Load || w_tick) begin
                r_presc <= '0;
            end else if (Start_Stop) begin
                r_presc <= r_presc + c_PW'(1);
            end
            if (Load) begin
                r_count <= w_load_val;
            end else if (w_tick) begin
                r_count <= w_count_nxt;
            end
            r_wrap <= w_tick & ~Load & w_carry[DIGITS];
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= c_ST_LIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (Load) begin
            w_state_nxt = c_ST_LIVE;
        end else if (Lap) begin
            w_state_nxt = (r_state == c_ST_LIVE) ? c_ST_FROZEN : c_ST_LIVE;
        end
    end

    // Loading on entry to LIVE as well as while LIVE lets a Lap capture
    // the count when freezing and show the live count right after unfreezing.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_disp <= '0;
        end else if (r_state == c_ST_LIVE || w_state_nxt == c_ST_LIVE) begin
            r_disp <= r_count;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_seg  <= 8'hC0;
        end else begin
            if (r_scan == c_SW'(SCAN_DIV - 1)) begin
                r_scan <= '0;
                r_idx  <= (r_idx == c_IW'(DIGITS - 1)) ? '0 : r_idx + c_IW'(1);
            end else begin
                r_scan <= r_scan + c_SW'(1);
            end
            r_seg <= {1'b1, f_seg7(w_disp_dig[r_idx])};
        end
    end

    assign AN    = ~(DIGITS'(1) << r_idx);
    assign Seg   = r_seg;
    assign Wrap  = r_wrap;
    assign Count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_bcd_updown_timer.sv
// ============================================================================
// Module   : tb_bcd_updown_timer
// Brief    : Directed self-checking bench for bcd_updown_timer (4 digits,
//            tick every 4 cycles, scan advance every 2 cycles).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_updown_timer;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic        CLK;
    logic        CLR;
    logic        Start_Stop;
    logic        Dir;
    logic        Load;
    logic [15:0] Load_Data;
    logic        Lap;
    logic [3:0]  AN;
    logic [7:0]  Seg;
    logic        Wrap;
    logic [15:0] Count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bcd_updown_timer #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .Start_Stop (Start_Stop),
        .Dir        (Dir),
        .Load       (Load),
        .Load_Data  (Load_Data),
        .Lap        (Lap),
        .AN         (AN),
        .Seg        (Seg),
        .Wrap       (Wrap),
        .Count      (Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 8'b1_1000000;
            4'd1:    seg_of = 8'b1_1111001;
            4'd2:    seg_of = 8'b1_0100100;
            4'd3:    seg_of = 8'b1_0110000;
            4'd4:    seg_of = 8'b1_0011001;
            4'd5:    seg_of = 8'b1_0010010;
            4'd6:    seg_of = 8'b1_0000010;
            4'd7:    seg_of = 8'b1_1111000;
            4'd8:    seg_of = 8'b1_0000000;
            4'd9:    seg_of = 8'b1_0010000;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    // Scan position after edge c (counted from reset release) is (c/2)%4;
    // Seg after edge c shows the digit selected after edge c-1.
    function automatic logic [3:0] an_at(input int c);
        logic [3:0] one;
        one = 4'b0001;
        an_at = ~(one << ((c / 2) % 4));
    endfunction

    function automatic logic [7:0] seg_at(input logic [15:0] v, input int c);
        int k;
        k = ((c - 1) / 2) % 4;
        seg_at = seg_of(v[k*4 +: 4]);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        Load = 1'b1;
        Load_Data = v;
        step(1);
        Load = 1'b0;
    endtask

    task automatic test_reset;
        CLR = 1'b1; Start_Stop = 1'b0; Dir = 1'b1; Load = 1'b0;
        Load_Data = 16'h0000; Lap = 1'b0;
        #2 CLR = 1'b0;
        #1;
        n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL rst_count: got %h want %h", Count, 16'h0000); end
        n_vec++; if (AN !== 4'b1110) begin n_err++; $display("FAIL rst_an: got %b want %b", AN, 4'b1110); end
        n_vec++; if (Seg !== 8'hC0) begin n_err++; $display("FAIL rst_seg: got %h want %h", Seg, 8'hC0); end
        n_vec++; if (Wrap !== 1'b0) begin n_err++; $display("FAIL rst_wrap: got %b want %b", Wrap, 1'b0); end
        @(posedge CLK);
        #1;
        CLR = 1'b1;
        cyc = 0;
    endtask

    task automatic test_count_up;
        int wraps;
        wraps = 0;
        Start_Stop = 1'b1; Dir = 1'b1;
        step(3);
        n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL up_pre_tick: got %h want %h", Count, 16'h0000); end
        step(1);
        n_vec++; if (Count !== 16'h0001) begin n_err++; $display("FAIL up_first_tick: got %h want %h", Count, 16'h0001); end
        for (int i = 0; i < 36; i++) begin
            step(1);
            if (Wrap === 1'b1) wraps++;
        end
        n_vec++; if (Count !== 16'h0010) begin n_err++; $display("FAIL up_40: got %h want %h", Count, 16'h0010); end
        n_vec++; if (wraps !== 0) begin n_err++; $display("FAIL up_no_wrap: got %0d pulses want 0", wraps); end
        Start_Stop = 1'b0;
    endtask

    task automatic test_wrap_up;
        Start_Stop = 1'b0;
        do_load(16'h9998);
        n_vec++; if (Count !== 16'h9998) begin n_err++; $display("FAIL wu_load: got %h want %h", Count, 16'h9998); end
        Start_Stop = 1'b1; Dir = 1'b1;
        step(4);
        n_vec++; if (Count !== 16'h9999) begin n_err++; $display("FAIL wu_9999: got %h want %h", Count, 16'h9999); end
        n_vec++; if (Wrap !== 1'b0) begin n_err++; $display("FAIL wu_wrap0: got %b want %b", Wrap, 1'b0); end
        step(4);
        n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL wu_0000: got %h want %h", Count, 16'h0000); end
        n_vec++; if (Wrap !== 1'b1) begin n_err++; $display("FAIL wu_wrap1: got %b want %b", Wrap, 1'b1); end
        step(1);
        n_vec++; if (Wrap !== 1'b0) begin n_err++; $display("FAIL wu_wrap_end: got %b want %b", Wrap, 1'b0); end
        Start_Stop = 1'b0;
    endtask

    task automatic test_wrap_down;
        do_load(16'h0001);
        Start_Stop = 1'b1; Dir = 1'b0;
        step(4);
        n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL wd_0000: got %h want %h", Count, 16'h0000); end
        n_vec++; if (Wrap !== 1'b0) begin n_err++; $display("FAIL wd_wrap0: got %b want %b", Wrap, 1'b0); end
        step(4);
        n_vec++; if (Count !== 16'h9999) begin n_err++; $display("FAIL wd_9999: got %h want %h", Count, 16'h9999); end
        n_vec++; if (Wrap !== 1'b1) begin n_err++; $display("FAIL wd_wrap1: got %b want %b", Wrap, 1'b1); end
        step(1);
        n_vec++; if (Wrap !== 1'b0) begin n_err++; $display("FAIL wd_wrap_end: got %b want %b", Wrap, 1'b0); end
        Start_Stop = 1'b0; Dir = 1'b1;
    endtask

    task automatic test_load;
        do_load(16'h12F4);
        n_vec++; if (Count !== 16'h1204) begin n_err++; $display("FAIL ld_sanitize: got %h want %h", Count, 16'h1204); end
        do_load(16'hABCD);
        n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL ld_all_bad: got %h want %h", Count, 16'h0000); end
        do_load(16'h0500);
        Start_Stop = 1'b1; Dir = 1'b1;
        step(3);
        // next edge is a tick; a load of 9999 must beat the increment and not wrap
        do_load(16'h9999);
        n_vec++; if (Count !== 16'h9999) begin n_err++; $display("FAIL ld_on_tick: got %h want %h", Count, 16'h9999); end
        n_vec++; if (Wrap !== 1'b0) begin n_err++; $display("FAIL ld_on_tick_wrap: got %b want %b", Wrap, 1'b0); end
        step(3);
        n_vec++; if (Count !== 16'h9999) begin n_err++; $display("FAIL ld_presc_clr: got %h want %h", Count, 16'h9999); end
        step(1);
        n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL ld_after_tick: got %h want %h", Count, 16'h0000); end
        n_vec++; if (Wrap !== 1'b1) begin n_err++; $display("FAIL ld_after_wrap: got %b want %b", Wrap, 1'b1); end
        Start_Stop = 1'b0;
    endtask

    task automatic test_lap;
        do_load(16'h0005);
        Lap = 1'b1; step(1); Lap = 1'b0;
        Start_Stop = 1'b1; Dir = 1'b1;
        step(12);
        Start_Stop = 1'b0;
        n_vec++; if (Count !== 16'h0008) begin n_err++; $display("FAIL lap_count: got %h want %h", Count, 16'h0008); end
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_vec++; if (Seg !== seg_at(16'h0005, cyc)) begin n_err++; $display("FAIL lap_frozen_seg: got %h want %h", Seg, seg_at(16'h0005, cyc)); end
            n_vec++; if (AN !== an_at(cyc)) begin n_err++; $display("FAIL lap_frozen_an: got %b want %b", AN, an_at(cyc)); end
        end
        Lap = 1'b1; step(1); Lap = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_vec++; if (Seg !== seg_at(16'h0008, cyc)) begin n_err++; $display("FAIL lap_live_seg: got %h want %h", Seg, seg_at(16'h0008, cyc)); end
        end
        Lap = 1'b1; step(1); Lap = 1'b0;
        do_load(16'h0123);
        step(1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_vec++; if (Seg !== seg_at(16'h0123, cyc)) begin n_err++; $display("FAIL lap_load_unfreeze: got %h want %h", Seg, seg_at(16'h0123, cyc)); end
        end
    endtask

    task automatic test_hold;
        do_load(16'h0000);
        Start_Stop = 1'b1; Dir = 1'b1;
        step(2);
        Start_Stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            n_vec++; if (AN !== an_at(cyc)) begin n_err++; $display("FAIL hold_an: got %b want %b", AN, an_at(cyc)); end
            n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL hold_count: got %h want %h", Count, 16'h0000); end
        end
        Start_Stop = 1'b1;
        step(1);
        n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL hold_presc3: got %h want %h", Count, 16'h0000); end
        step(1);
        n_vec++; if (Count !== 16'h0001) begin n_err++; $display("FAIL hold_resume: got %h want %h", Count, 16'h0001); end
        Start_Stop = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_load(16'h9999);
        Lap = 1'b1; step(1); Lap = 1'b0;
        Start_Stop = 1'b1; Dir = 1'b1;
        step(3);
        #3 CLR = 1'b0;
        #1;
        n_vec++; if (Count !== 16'h0000) begin n_err++; $display("FAIL mid_count: got %h want %h", Count, 16'h0000); end
        n_vec++; if (AN !== 4'b1110) begin n_err++; $display("FAIL mid_an: got %b want %b", AN, 4'b1110); end
        n_vec++; if (Seg !== 8'hC0) begin n_err++; $display("FAIL mid_seg: got %h want %h", Seg, 8'hC0); end
        n_vec++; if (Wrap !== 1'b0) begin n_err++; $display("FAIL mid_wrap: got %b want %b", Wrap, 1'b0); end
        @(posedge CLK);
        #1;
        n_vec++; if (Wrap !== 1'b0) begin n_err++; $display("FAIL mid_wrap_held: got %b want %b", Wrap, 1'b0); end
        CLR = 1'b1;
        cyc = 0;
        step(4);
        Start_Stop = 1'b0;
        n_vec++; if (Count !== 16'h0001) begin n_err++; $display("FAIL mid_restart: got %h want %h", Count, 16'h0001); end
        step(1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            n_vec++; if (Seg !== seg_at(16'h0001, cyc)) begin n_err++; $display("FAIL mid_live_seg: got %h want %h", Seg, seg_at(16'h0001, cyc)); end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load();
        test_lap();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
